// File: rtl/array_command_sequencer.sv
// Host-side command sequencer for the PE array: FIFO-buffers host commands and issues them one at a time.
// Latency: 3 cycles minimum from FIFO pop to cmd_done (IDLE pop, ISSUE, WAIT with every PE ready).
// Backpressure: host_ready drops while the FIFO is full; the array throttles issue through pe_ready.
// Optional macro SEQ_TIMEOUT_EN adds a per-command wait limit and a sticky timeout_err flag.
module array_command_sequencer #(
  parameter int PRECISION        = 8,
  parameter int OUTPUT_PRECISION = 32,
  parameter int NUM_PE           = 16,
  parameter int FIFO_DEPTH       = 4,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                                 CLK,
  input  logic                                 reset_n,
  input  logic                                 host_valid,
  output logic                                 host_ready,
  input  logic [2:0]                           host_cmd,
  input  logic                                 host_image,
  input  logic [PRECISION-1:0]                 host_a,
  input  logic [PRECISION-1:0]                 host_b,
  input  logic [OUTPUT_PRECISION-1:0]          host_s,
  output logic [2:0]                           command_to_execute,
  output logic                                 image_to_shift,
  output logic [PRECISION-1:0]                 a_overwrite,
  output logic [PRECISION-1:0]                 b_overwrite,
  output logic [OUTPUT_PRECISION-1:0]          s_out_overwrite,
  output logic                                 ack,
  input  logic [NUM_PE-1:0]                    pe_ready,
  output logic                                 busy,
  output logic                                 cmd_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count,
  output logic                                 timeout_err
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  // Pointer wrap relies on natural overflow, so the depth must be a power of two.
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 16-bit wait counter");
  end

  typedef struct packed {
    logic [2:0]                  cmd;
    logic                        image;
    logic [PRECISION-1:0]        a;
    logic [PRECISION-1:0]        b;
    logic [OUTPUT_PRECISION-1:0] s;
  } entry_t;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACK, DRAIN} state_t;

  state_t        state, state_nxt;
  entry_t        mem [FIFO_DEPTH];
  entry_t        bus;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;
  logic          all_ready, any_ready;
  logic          tmo_hit;
  logic          timed_out;

  assign host_ready = (count != CW'(FIFO_DEPTH));
  assign push       = host_valid && host_ready;
  assign pop        = (state == IDLE) && (count != '0);
  assign all_ready  = &pe_ready;
  assign any_ready  = |pe_ready;
  assign busy       = (state != IDLE) || (count != '0);
  assign fifo_count = count;

  assign command_to_execute = bus.cmd;
  assign image_to_shift     = bus.image;
  assign a_overwrite        = bus.a;
  assign b_overwrite        = bus.b;
  assign s_out_overwrite    = bus.s;

  // FIFO storage: payload only, no reset needed since count gates every read
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= '{cmd: host_cmd, image: host_image, a: host_a, b: host_b, s: host_s};
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Command bus registers: load only on pop, otherwise hold the last issued command
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) bus <= '0;
    else if (pop) bus <= mem[rd_ptr];
  end

`ifdef SEQ_TIMEOUT_EN
  logic [15:0] wait_cnt;

  assign tmo_hit = (state == WAIT) && !all_ready && (wait_cnt == 16'(TIMEOUT_CYCLES - 1));

  // Wait counter restarts in ISSUE; timed_out marks the current ACK as a forced one
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt    <= '0;
      timed_out   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (state == ISSUE) begin
        wait_cnt  <= '0;
        timed_out <= 1'b0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (tmo_hit) begin
        timed_out   <= 1'b1;
        timeout_err <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timed_out   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and handshake outputs; ack is high whenever no command is being driven
  always_comb begin
    state_nxt = state;
    ack       = 1'b1;
    cmd_done  = 1'b0;
    case (state)
      IDLE:  if (count != '0) state_nxt = ISSUE;
      ISSUE: begin
        ack       = 1'b0;
        state_nxt = WAIT;
      end
      WAIT: begin
        ack = 1'b0;
        if (all_ready || tmo_hit) state_nxt = ACK;
      end
      ACK: begin
        cmd_done  = !timed_out;
        state_nxt = DRAIN;
      end
      DRAIN: if (!any_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_array_command_sequencer.sv
// Scoreboard bench for array_command_sequencer: stimulus queues expected commands, a monitor checks them.
// The monitor also plays the PE array, raising pe_ready per the in-flight command's ready profile.
// Build with SEQ_TIMEOUT_EN defined to exercise the timeout path (TIMEOUT_CYCLES = 8).
module tb_array_command_sequencer;

  localparam int TMO = 8;

  typedef struct {
    logic [2:0]  cmd;
    logic        img;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [31:0] s;
    int          partial;  // WAIT cycles with a partial ready mask before all PEs are ready
    bit          zero;     // partial phase drives all-zero instead of 0x7FFF
    int          low;      // expected ack-low cycles (ISSUE + WAIT)
    bit          done;     // expected cmd_done at the ack rise
  } exp_t;

  logic        CLK = 1'b0;
  logic        reset_n;
  logic        host_valid;
  logic        host_ready;
  logic [2:0]  host_cmd;
  logic        host_image;
  logic [7:0]  host_a, host_b;
  logic [31:0] host_s;
  logic [2:0]  command_to_execute;
  logic        image_to_shift;
  logic [7:0]  a_overwrite, b_overwrite;
  logic [31:0] s_out_overwrite;
  logic        ack;
  logic [15:0] pe_ready;
  logic        busy;
  logic        cmd_done;
  logic [2:0]  fifo_count;
  logic        timeout_err;

  exp_t exp_q[$];
  exp_t cur;
  bit   infl = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  array_command_sequencer #(
    .PRECISION(8), .OUTPUT_PRECISION(32), .NUM_PE(16), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK(CLK), .reset_n(reset_n),
    .host_valid(host_valid), .host_ready(host_ready), .host_cmd(host_cmd), .host_image(host_image),
    .host_a(host_a), .host_b(host_b), .host_s(host_s),
    .command_to_execute(command_to_execute), .image_to_shift(image_to_shift),
    .a_overwrite(a_overwrite), .b_overwrite(b_overwrite), .s_out_overwrite(s_out_overwrite),
    .ack(ack), .pe_ready(pe_ready), .busy(busy), .cmd_done(cmd_done),
    .fifo_count(fifo_count), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit times_out(input int partial);
`ifdef SEQ_TIMEOUT_EN
    return partial >= TMO;
`else
    return (partial < 0);
`endif
  endfunction

  // Offer one command at a negedge; only an accepted command enters the scoreboard
  task automatic push(input logic [2:0] c, input logic img, input logic [7:0] a, input logic [7:0] b,
                      input logic [31:0] s, input int partial, input bit zero);
    exp_t e;
    host_valid = 1'b1; host_cmd = c; host_image = img; host_a = a; host_b = b; host_s = s;
    if (host_ready) begin
      e.cmd = c; e.img = img; e.a = a; e.b = b; e.s = s;
      e.partial = partial; e.zero = zero;
      e.low  = times_out(partial) ? 1 + TMO : 2 + partial;
      e.done = !times_out(partial);
      exp_q.push_back(e);
    end
    @(posedge CLK);
    @(negedge CLK);
    host_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || infl || exp_q.size() != 0) && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 2000) begin
      n_chk++; n_fail++;
      $display("FAIL %s: timed out waiting for idle, busy=%0b queued=%0d", name, busy, exp_q.size());
    end
  endtask

  task automatic wait_ack_low(input string name);
    int n = 0;
    while (ack && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) begin
      n_chk++; n_fail++;
      $display("FAIL %s: ack never fell, got ack=%0b expected 0", name, ack);
    end
  endtask

  // Monitor and PE-array model: pop on ack fall, check bus every issued cycle, check timing at ack rise
  initial begin
    bit prev_ack = 1'b1;
    int lowcnt = 0;
    pe_ready = '0;
    forever begin
      @(negedge CLK);
      if (!reset_n) begin
        infl = 1'b0; prev_ack = 1'b1; lowcnt = 0; pe_ready = '0;
        continue;
      end
      if (prev_ack && !ack) begin
        chk("issue_has_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          infl = 1'b1;
          lowcnt = 0;
        end
      end
      if (infl && !ack) begin
        lowcnt++;
        chk("bus_stable", {command_to_execute, image_to_shift, a_overwrite, b_overwrite, s_out_overwrite},
            {cur.cmd, cur.img, cur.a, cur.b, cur.s});
      end
      if (infl && ack && !prev_ack) begin
        chk("ack_low_cycles", 64'(lowcnt), 64'(cur.low));
        chk("cmd_done_at_ack", 64'(cmd_done), 64'(cur.done));
        infl = 1'b0;
      end else begin
        chk("cmd_done_quiet", 64'(cmd_done), 64'd0);
      end
      prev_ack = ack;
      if (infl && !ack) begin
        if (lowcnt == 1)                  pe_ready = '0;
        else if (lowcnt <= 1 + cur.partial) pe_ready = cur.zero ? 16'h0000 : 16'h7FFF;
        else                              pe_ready = 16'hFFFF;
      end else begin
        pe_ready = '0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; host_valid = 1'b0; host_cmd = '0; host_image = 1'b0;
    host_a = '0; host_b = '0; host_s = '0;
    repeat (3) @(negedge CLK);
    chk("reset_ack", 64'(ack), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_count", 64'(fifo_count), 64'd0);
    chk("reset_host_ready", 64'(host_ready), 64'd1);
    chk("reset_cmd_done", 64'(cmd_done), 64'd0);
    chk("reset_tmo", 64'(timeout_err), 64'd0);
    chk("reset_bus", 64'(command_to_execute), 64'd0);
    #2 reset_n = 1'b1;
    @(negedge CLK);

    // Reset asserted mid-WAIT takes effect without a clock edge and abandons the command
    push(3'b011, 1'b1, 8'h11, 8'h22, 32'h33, 50, 1'b0);
    wait_ack_low("rst_mid_wait");
    repeat (4) @(negedge CLK);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_ack", 64'(ack), 64'd1);
    chk("rst_async_busy", 64'(busy), 64'd0);
    chk("rst_async_count", 64'(fifo_count), 64'd0);
    chk("rst_async_cmd", 64'(command_to_execute), 64'd0);
    chk("rst_async_img", 64'(image_to_shift), 64'd0);
    exp_q.delete();
    @(negedge CLK);
    #2 reset_n = 1'b1;
    @(negedge CLK);

    // Single shift-left on image B at minimum latency
    push(3'b011, 1'b1, 8'h00, 8'h00, 32'h0, 0, 1'b0);
    wait_idle("single_shift");

    // Partial ready mask for 10 WAIT cycles keeps ack low
    push(3'b001, 1'b0, 8'h00, 8'h00, 32'h0, 10, 1'b0);
    wait_idle("partial_ready");

    // Overwrite-value loads
    push(3'b101, 1'b0, 8'h5A, 8'hA5, 32'h0, 0, 1'b0);
    push(3'b110, 1'b0, 8'h00, 8'h00, 32'hDEADBEEF, 0, 1'b0);
    wait_idle("load_values");

    // FIFO full: one command stalls the array, four fill the FIFO, the fifth is dropped
    push(3'b000, 1'b0, 8'h01, 8'h02, 32'h3, 20, 1'b0);
    wait_ack_low("fifo_stall");
    push(3'b001, 1'b0, 8'h00, 8'h00, 32'h0, 0, 1'b0);
    push(3'b010, 1'b1, 8'h00, 8'h00, 32'h0, 0, 1'b0);
    push(3'b011, 1'b0, 8'h00, 8'h00, 32'h0, 0, 1'b0);
    push(3'b100, 1'b1, 8'h00, 8'h00, 32'h0, 0, 1'b0);
    chk("fifo_full_ready", 64'(host_ready), 64'd0);
    chk("fifo_full_count", 64'(fifo_count), 64'd4);
    push(3'b111, 1'b1, 8'hFF, 8'hFF, 32'hFFFFFFFF, 0, 1'b0);
    chk("fifo_drop_count", 64'(fifo_count), 64'd4);
    wait_idle("fifo_full");

`ifdef SEQ_TIMEOUT_EN
    // Array never ready: forced ACK without cmd_done, then the next command runs normally
    @(negedge CLK);
    #2 reset_n = 1'b0;
    @(negedge CLK);
    #2 reset_n = 1'b1;
    @(negedge CLK);
    chk("tmo_cleared", 64'(timeout_err), 64'd0);
    push(3'b010, 1'b1, 8'h00, 8'h00, 32'h0, 100, 1'b1);
    push(3'b100, 1'b0, 8'h00, 8'h00, 32'h0, 0, 1'b0);
    wait_idle("timeout");
    chk("tmo_sticky", 64'(timeout_err), 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
